// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Shares one word-addressed memory between the load/store port and fetch.
// Handles RV32I byte/half extension and read-modify-write sub-word stores.
// Rev    : 1.0
// ============================================================================

module dmem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_err,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_starve;
    logic [31:0]       r_merge;
    logic [ADDR_W-1:0] r_rmw_addr;

    logic              w_d_elig;
    logic              w_i_elig;
    logic              w_idle;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_err;
    logic              w_sub_store;
    logic [ADDR_W-1:0] w_d_idx;
    logic [ADDR_W-1:0] w_i_idx;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;
    logic              w_unused;

    assign w_unused = ^{d_addr[31:ADDR_W+2], i_addr[31:ADDR_W+2], i_addr[1:0],
                        d_wdata[31:16]};

    assign w_d_idx = d_addr[ADDR_W+1:2];
    assign w_i_idx = i_addr[ADDR_W+1:2];

    // A port whose ack is high this cycle is finishing and may not be regranted.
    assign w_d_elig  = d_req && !d_ack;
    assign w_i_elig  = i_req && !i_ack;
    assign w_idle    = (r_state == S_IDLE) && !rst;
    assign w_grant_i = w_idle && w_i_elig && (!w_d_elig || (r_starve == C_STARVE_MAX));
    assign w_grant_d = w_idle && w_d_elig && !w_grant_i;
    assign w_sub_store = d_we && (d_funct3 != 3'd2);

    always_comb begin
        w_err = 1'b0;
        if (d_we) begin
            if (d_funct3 > 3'd2) begin
                w_err = 1'b1;
            end else if (d_funct3 == 3'd1) begin
                w_err = d_addr[0];
            end else if (d_funct3 == 3'd2) begin
                w_err = |d_addr[1:0];
            end
        end else begin
            case (d_funct3)
                3'd0, 3'd4: w_err = 1'b0;
                3'd1, 3'd5: w_err = d_addr[0];
                3'd2:       w_err = |d_addr[1:0];
                default:    w_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rdata[{d_addr[1:0], 3'b000} +: 8];
        w_half = mem_rdata[{d_addr[1], 4'b0000} +: 16];
        case (d_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd2:    w_load = mem_rdata;
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // Old word with the addressed lane replaced; written back in the RMW cycle.
    always_comb begin
        w_merge = mem_rdata;
        if (d_funct3[0]) begin
            w_merge[{d_addr[1], 4'b0000} +: 16] = d_wdata[15:0];
        end else begin
            w_merge[{d_addr[1:0], 3'b000} +: 8] = d_wdata[7:0];
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 32'd0;
        w_state_nxt = r_state;
        if (r_state == S_RMW) begin
            w_state_nxt = S_IDLE;
            if (!rst) begin
                mem_write = 1'b1;
                mem_addr  = r_rmw_addr;
                mem_wdata = r_merge;
            end
        end else if (w_grant_i) begin
            mem_read = 1'b1;
            mem_addr = w_i_idx;
        end else if (w_grant_d && !w_err) begin
            mem_addr = w_d_idx;
            if (d_we && (d_funct3 == 3'd2)) begin
                mem_write = 1'b1;
                mem_wdata = d_wdata;
            end else begin
                mem_read = 1'b1;
            end
            if (w_sub_store) begin
                w_state_nxt = S_RMW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_starve   <= '0;
            r_merge    <= 32'd0;
            r_rmw_addr <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 32'd0;
            i_ack      <= 1'b0;
            i_rdata    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            i_ack   <= 1'b0;

            if (w_grant_i) begin
                i_ack   <= 1'b1;
                i_rdata <= mem_rdata;
            end

            if (w_grant_d) begin
                if (w_err) begin
                    d_ack   <= 1'b1;
                    d_err   <= 1'b1;
                    d_rdata <= 32'd0;
                end else if (!d_we) begin
                    d_ack   <= 1'b1;
                    d_rdata <= w_load;
                end else if (!w_sub_store) begin
                    d_ack   <= 1'b1;
                    d_rdata <= 32'd0;
                end else begin
                    r_merge    <= w_merge;
                    r_rmw_addr <= w_d_idx;
                end
            end

            if (r_state == S_RMW) begin
                d_ack   <= 1'b1;
                d_rdata <= 32'd0;
            end

            if (!w_i_elig || w_grant_i) begin
                r_starve <= '0;
            end else if (w_grant_d && (r_starve != C_STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
